// File: rtl/fp96_normalize.sv
// fp96_normalize: three-stage normalizer from expanded-significand FP96X to FP96N with guard/sticky,
// gradual underflow, overflow to infinity and inf/NaN passthrough.
module fp96_normalize (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         valid_i,
    input  logic [178:0] i,
    output logic         valid_o,
    output logic [98:0]  o,
    output logic         ovf_o,
    output logic         unf_o
);
    logic [7:0]   p;
    logic         s1_v, s1_sign, s1_zero, s1_spec;
    logic [14:0]  s1_ee;
    logic [7:0]   s1_p;
    logic [162:0] s1_sig;
    logic signed [16:0] lz, ex;
    logic         right, den, so;
    logic [7:0]   sh;
    logic [160:0] al;
    logic         s2_v, s2_sign, s2_zero, s2_spec, s2_den;
    logic signed [16:0] s2_exp;
    logic [82:0]  s2_sig;
    logic         ovf;

    always_comb begin
        p = '0;
        for (int k = 0; k < 163; k++)
            if (i[k]) p = 8'(k);
    end

    // lz is negative for the right-shift case, so ee-lz covers ee+r as well
    always_comb begin
        lz    = 17'sd160 - $signed({9'd0, s1_p});
        ex    = $signed({2'b0, s1_ee}) - lz;
        right = s1_p > 8'd160;
        den   = !right && ex < 17'sd1;
        sh    = den ? s1_ee[7:0] - 8'd1 : lz[7:0];
        al    = right ? 161'(s1_sig >> (s1_p - 8'd160)) : 161'(s1_sig << sh);
        so    = right && ((s1_p == 8'd162) ? |s1_sig[1:0] : s1_sig[0]);
        ovf   = !s2_spec && !s2_zero && s2_exp >= 17'sd32767;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            valid_o <= 1'b0;
            o       <= '0;
            ovf_o   <= 1'b0;
            unf_o   <= 1'b0;
        end else if (ce) begin
            s1_v    <= valid_i;
            s2_v    <= s1_v;
            valid_o <= s2_v;
            ovf_o   <= ovf;
            unf_o   <= !s2_spec && !s2_zero && s2_den;
            o       <= s2_spec ? {s2_sign, 15'h7FFF, s2_sig} :
                       s2_zero ? {s2_sign, 98'd0} :
                       ovf     ? {s2_sign, 15'h7FFF, 83'd0} :
                                 {s2_sign, s2_den ? 15'd0 : s2_exp[14:0], s2_sig};
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            s1_sign <= i[178];
            s1_zero <= ~|i[162:0];
            s1_spec <= i[177:163] == 15'h7FFF;
            s1_ee   <= (i[177:163] == 15'd0) ? 15'd1 : i[177:163];
            s1_p    <= p;
            s1_sig  <= i[162:0];
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_spec <= s1_spec;
            s2_den  <= den;
            s2_exp  <= ex;
            s2_sig  <= s1_spec ? {s1_sig[160:80], 2'b00} : {al[160:79], |al[78:0] | so};
        end
    end
endmodule
